memory_word_sequencer: RTL

MEMORY_WORD_SEQUENCER -- requirements
Module: memory_word_sequencer

---
 rtl/memory_word_sequencer_if.sv | 30 +++
 rtl/memory_word_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/memory_word_sequencer_if.sv
// Word-access request and 8-bit memory port bundle for memory_word_sequencer.
// slave is the sequencer side; master is the requester/memory side.
interface memory_word_sequencer_if;
    logic        Start;
    logic        Write;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic [15:0] MemAddr;
    logic        MemCS;
    logic        MemWr;
    logic [7:0]  MemDOut;
    logic [7:0]  MemDIn;
    logic [15:0] RData;
    logic        Busy;
    logic        Done;
    logic        Fault;

    // Handshake: Start is taken only while Busy=0; Done pulses once per accepted
    // Start; Fault is meaningful only while Done=1. Memory reads return MemDIn
    // one cycle after the MemCS=1, MemWr=0 beat.
    modport slave (
        input  Start, Write, Addr, WData, MemDIn,
        output MemAddr, MemCS, MemWr, MemDOut, RData, Busy, Done, Fault
    );

    modport master (
        output Start, Write, Addr, WData, MemDIn,
        input  MemAddr, MemCS, MemWr, MemDOut, RData, Busy, Done, Fault
    );
endinterface

// File: rtl/memory_word_sequencer.sv
// Splits one 16-bit word access into two little-endian byte beats on an 8-bit memory.
// Define MWS_ALIGN_CHECK_EN to reject odd word addresses with a one-cycle Fault completion.
module memory_word_sequencer (
    input  logic                           Clock,
    input  logic                           Reset,
    memory_word_sequencer_if.slave         bus,
    output logic [1:0]                     debug_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  lo_q;
    logic [15:0] rdata_q;
    logic        fault_q;
    logic        misaligned;

`ifdef MWS_ALIGN_CHECK_EN
    assign misaligned = bus.Addr[0];
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            lo_q    <= 8'h00;
            rdata_q <= 16'h0000;
            fault_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        wr_q    <= bus.Write;
                        addr_q  <= bus.Addr;
                        wdata_q <= bus.WData;
                        fault_q <= misaligned;
                    end
                end
                // MemDIn now carries the byte selected during LO.
                HI: begin
                    if (!wr_q) lo_q <= bus.MemDIn;
                end
                FIN: begin
                    if (!wr_q && !fault_q) rdata_q <= {bus.MemDIn, lo_q};
                    fault_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = misaligned ? FIN : LO;
            LO:      state_next = HI;
            HI:      state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.MemCS   = 1'b0;
        bus.MemWr   = 1'b0;
        bus.MemAddr = 16'h0000;
        bus.MemDOut = 8'h00;
        case (state)
            LO: begin
                bus.MemCS   = 1'b1;
                bus.MemWr   = wr_q;
                bus.MemAddr = addr_q;
                bus.MemDOut = wdata_q[7:0];
            end
            HI: begin
                bus.MemCS   = 1'b1;
                bus.MemWr   = wr_q;
                bus.MemAddr = addr_q + 16'd1;
                bus.MemDOut = wdata_q[15:8];
            end
            default: ;
        endcase
    end

    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = (state == FIN);
    assign bus.Fault   = (state == FIN) && fault_q;
    assign bus.RData   = rdata_q;
    assign debug_state = state;

endmodule
